pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
Control unit for the 5-stage pipelined ARM datapath. Decodes the instruction held in the Decode stage and generates the D-stage controls. Carries the remaining controls through the E/M/W pipeline registers. Holds the NZCV flags register, evaluates the condition field in Execute and gates side effects. Also exports the hazard-relevant signals.

Parameters:
(none; widths are fixed by the ISA subset)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
InstrD  in  32  instruction in D stage (from datapath F/D register)
ALUFlags  in  4  NZCV from datapath ALU, E stage
FlushE  in  1  hazard unit: bubble the D->E transfer
RegSrcD  out  2  [1]=STR reads Rd as src2, [0]=branch reads PC
ImmSrcD  out  2  00 imm8 rot, 01 imm12, 10 imm24 branch
ALUSrcE  out  1  1=immediate operand
ALUControlE  out  4  ALU op, see encoding
BranchTakenE  out  1  taken branch in E
MemWriteM  out  1  data-memory write enable
RegWriteM  out  1  for forwarding/hazard logic
MemtoRegE  out  1  load in E (load-use stall)
RegWriteW  out  1  register-file write
MemtoRegW  out  1  result select
PCSrcW  out  1  write to R15 in W
PCWrPendingF  out  1  PC write in D, E or M

Behaviour:
- Field decode: cond=InstrD[31:28], op=[27:26], funct=[25:20], Rd=[15:12].
- ALU encoding: ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, MOV 0101 (pass SrcB).
- op=00 data-processing: RegSrc 00, ImmSrc 00, ALUSrc=funct[5]. cmd=funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV.
  - 1010 CMP: SUB, RegW=0, FlagW=11 always.
  - Any other cmd: NOP, all enables 0.
  - RegW=1 except CMP.
  - FlagW when S=funct[0]: 11 for ADD/SUB, 10 for logical/MOV.
- op=01 memory: ImmSrc 01, ALUSrc 1, ALUControl ADD if U=funct[3] else SUB.
  - L=funct[0]=1 (LDR): RegW=1, MemtoReg=1.
  - L=0 (STR): MemW=1, RegSrc 10.
- op=10 branch: RegSrc 01, ImmSrc 10, ALUSrc 1, ADD, Branch=1.
- op=11: NOP.
- PCS_D = RegW & (Rd==4'hF).
- D->E register, every cycle: RegW, MemW, MemtoReg, Branch, PCS, FlagW, ALUSrc, ALUControl, cond.
  - reset or FlushE: all enables (RegW, MemW, MemtoReg, Branch, PCS, FlagW) become 0.
- Condition check (E, combinational), using the flags register:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 never (0).
- Flags register update at end of the E cycle when CondEx:
  - FlagWE[1]: NZ <= ALUFlags[3:2].
  - FlagWE[0]: CV <= ALUFlags[1:0].
  - The next instruction's E stage sees the updated flags; no same-cycle bypass.
- Gated outputs:
  - BranchTakenE = BranchE & CondEx (combinational).
  - E->M registers: RegW&CondEx, MemW&CondEx, MemtoReg, PCS&CondEx.
- M->W register: RegWrite, MemtoReg, PCS.
- Latency: an instruction in D at cycle t is in E at t+1, M at t+2, W at t+3.
- PCWrPendingF = PCS_D | PCSE | PCSrcM.
- Reset values: all E/M/W registers 0 (ALUControlE 0000, ALUSrcE 0); flags 0000. D outputs are purely combinational from InstrD.
- Reset mid-operation clears all in-flight enables in the same edge; no partial writes after reset.
- FlushE and a flag-setting instruction in E in the same cycle: the E instruction still completes, including the flags update.

Decomposition:
- Package pipeline_ctrl_pkg: ALU op constants, cond-code constants, op-field constants (DP/MEM/BR).
- One sub-module cond_unit: NZCV flags register, condition evaluation, CondEx output.

Test Plan:
- Reset: hold reset 2 cycles with an arbitrary InstrD -> all E/M/W outputs 0; PCWrPendingF follows InstrD only; flags 0000.
- ADD R1,R2,#5 (0xE2821005):
  - at t+1: ALUSrcE=1, ALUControlE=0000.
  - RegWriteW=1 at t+3; MemtoRegW=0.
- CMP R1,R1 (0xE1510001) with ALUFlags=0100 in E:
  - then BEQ 0x0A000002 -> BranchTakenE=1 in its E cycle.
  - BNE 0x1A000002 -> BranchTakenE=0.
- LDR R2,[R0,#4] (0xE5902004):
  - RegSrcD=00, ImmSrcD=01.
  - MemtoRegE=1 at t+1; MemtoRegW=1 and RegWriteW=1 at t+3.
  - Same instruction with FlushE=1 at t -> MemtoRegE, RegWriteM, RegWriteW all 0.
- Conditional fail: flags Z=0, LDREQ (0x05902004) -> RegWriteM=0, RegWriteW=0, MemWriteM=0.
- MOV PC,R1 (0xE1A0F001):
  - PCWrPendingF=1 at t, t+1, t+2.
  - PCSrcW=1 at t+3, then 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipelined ARM control unit: ALU operation codes,
// condition-field codes, op-field classes and data-processing cmd codes.
package pipeline_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // FlagW: bit 1 updates NZ, bit 0 updates CV.
  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;
  localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/pipeline_controller_cond_unit.sv
// Condition unit: holds the NZCV flags register, evaluates the E-stage
// condition field against it and updates the flags at the end of the E cycle
// when the instruction executes.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (flags -> 0000)
//   cond        : condition field of the instruction in E
//   alu_flags   : NZCV produced by the ALU in E
//   flag_w      : [1] write NZ, [0] write CV (already cleared for bubbles)
//   cond_ex     : condition passes for the instruction in E
module cond_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  output logic       cond_ex
);

  logic [3:0] flags;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // No bypass: the updated flags are only visible to the next E instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Control unit for the 5-stage pipelined ARM datapath. Decodes InstrD into
// D-stage controls, carries the rest through the E/M/W registers, gates side
// effects with the condition result and exports hazard-related signals.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   InstrD                : instruction in D
//   ALUFlags              : NZCV from the ALU in E
//   FlushE                : bubble the D->E transfer
//   RegSrcD, ImmSrcD      : D-stage register-read / immediate-extend selects
//   ALUSrcE, ALUControlE  : E-stage ALU operand select and operation
//   BranchTakenE          : taken branch in E
//   MemtoRegE             : load in E
//   MemWriteM, RegWriteM  : M-stage write enables
//   RegWriteW, MemtoRegW  : W-stage write enable and result select
//   PCSrcW                : R15 written in W
//   PCWrPendingF          : an R15 write is in D, E or M
module pipeline_controller
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [3:0]  ALUFlags,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [3:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemWriteM,
  output logic        RegWriteM,
  output logic        MemtoRegE,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        PCWrPendingF
);

  logic [3:0] cond_d;
  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] rd_d;
  logic [3:0] cmd_d;
  logic       unused_instr_bits;

  logic       alu_src_d;
  logic [3:0] alu_control_d;
  logic       reg_w_d, mem_w_d, mem_to_reg_d, branch_d, pcs_d;
  logic [1:0] flag_w_d;

  logic       reg_w_e, mem_w_e, branch_e, pcs_e;
  logic [1:0] flag_w_e;
  logic [3:0] cond_e;
  logic       cond_ex_e;

  logic       mem_to_reg_m, pcs_m;

  assign cond_d  = InstrD[31:28];
  assign op_d    = InstrD[27:26];
  assign funct_d = InstrD[25:20];
  assign rd_d    = InstrD[15:12];
  assign cmd_d   = funct_d[4:1];
  assign unused_instr_bits = ^{InstrD[19:16], InstrD[11:0]};

  always_comb begin
    RegSrcD       = 2'b00;
    ImmSrcD       = 2'b00;
    alu_src_d     = 1'b0;
    alu_control_d = ALU_ADD;
    reg_w_d       = 1'b0;
    mem_w_d       = 1'b0;
    mem_to_reg_d  = 1'b0;
    branch_d      = 1'b0;
    flag_w_d      = FLAGW_NONE;
    case (op_d)
      OP_DP: begin
        alu_src_d = funct_d[5];
        reg_w_d   = 1'b1;
        case (cmd_d)
          CMD_ADD: begin
            alu_control_d = ALU_ADD;
            flag_w_d      = funct_d[0] ? FLAGW_ALL : FLAGW_NONE;
          end
          CMD_SUB: begin
            alu_control_d = ALU_SUB;
            flag_w_d      = funct_d[0] ? FLAGW_ALL : FLAGW_NONE;
          end
          CMD_AND: begin
            alu_control_d = ALU_AND;
            flag_w_d      = funct_d[0] ? FLAGW_NZ : FLAGW_NONE;
          end
          CMD_ORR: begin
            alu_control_d = ALU_ORR;
            flag_w_d      = funct_d[0] ? FLAGW_NZ : FLAGW_NONE;
          end
          CMD_EOR: begin
            alu_control_d = ALU_EOR;
            flag_w_d      = funct_d[0] ? FLAGW_NZ : FLAGW_NONE;
          end
          CMD_MOV: begin
            alu_control_d = ALU_MOV;
            flag_w_d      = funct_d[0] ? FLAGW_NZ : FLAGW_NONE;
          end
          // CMP sets flags regardless of S and never writes a register.
          CMD_CMP: begin
            alu_control_d = ALU_SUB;
            reg_w_d       = 1'b0;
            flag_w_d      = FLAGW_ALL;
          end
          default: reg_w_d = 1'b0;
        endcase
      end
      OP_MEM: begin
        ImmSrcD       = 2'b01;
        alu_src_d     = 1'b1;
        alu_control_d = funct_d[3] ? ALU_ADD : ALU_SUB;
        if (funct_d[0]) begin
          reg_w_d      = 1'b1;
          mem_to_reg_d = 1'b1;
        end else begin
          mem_w_d = 1'b1;
          RegSrcD = 2'b10;
        end
      end
      OP_BR: begin
        RegSrcD       = 2'b01;
        ImmSrcD       = 2'b10;
        alu_src_d     = 1'b1;
        alu_control_d = ALU_ADD;
        branch_d      = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcs_d = reg_w_d & (rd_d == 4'hF);

  cond_unit u_cond_unit (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond_e),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w_e),
    .cond_ex   (cond_ex_e)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_w_e      <= 1'b0;
      mem_w_e      <= 1'b0;
      MemtoRegE    <= 1'b0;
      branch_e     <= 1'b0;
      pcs_e        <= 1'b0;
      flag_w_e     <= FLAGW_NONE;
      ALUSrcE      <= 1'b0;
      ALUControlE  <= ALU_ADD;
      cond_e       <= 4'b0000;
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pcs_m        <= 1'b0;
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      PCSrcW       <= 1'b0;
    end else begin
      // A flush only kills the enables; the datapath selects pass through.
      reg_w_e      <= reg_w_d & ~FlushE;
      mem_w_e      <= mem_w_d & ~FlushE;
      MemtoRegE    <= mem_to_reg_d & ~FlushE;
      branch_e     <= branch_d & ~FlushE;
      pcs_e        <= pcs_d & ~FlushE;
      flag_w_e     <= FlushE ? FLAGW_NONE : flag_w_d;
      ALUSrcE      <= alu_src_d;
      ALUControlE  <= alu_control_d;
      cond_e       <= cond_d;
      RegWriteM    <= reg_w_e & cond_ex_e;
      MemWriteM    <= mem_w_e & cond_ex_e;
      mem_to_reg_m <= MemtoRegE;
      pcs_m        <= pcs_e & cond_ex_e;
      RegWriteW    <= RegWriteM;
      MemtoRegW    <= mem_to_reg_m;
      PCSrcW       <= pcs_m;
    end
  end

  assign BranchTakenE = branch_e & cond_ex_e;
  assign PCWrPendingF = pcs_d | pcs_e | pcs_m;

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

  logic        clk;
  logic        reset;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        FlushE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [3:0]  ALUControlE;
  logic        BranchTakenE;
  logic        MemWriteM;
  logic        RegWriteM;
  logic        MemtoRegE;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic        PCSrcW;
  logic        PCWrPendingF;

  pipeline_controller dut (
    .clk          (clk),
    .reset        (reset),
    .InstrD       (InstrD),
    .ALUFlags     (ALUFlags),
    .FlushE       (FlushE),
    .RegSrcD      (RegSrcD),
    .ImmSrcD      (ImmSrcD),
    .ALUSrcE      (ALUSrcE),
    .ALUControlE  (ALUControlE),
    .BranchTakenE (BranchTakenE),
    .MemWriteM    (MemWriteM),
    .RegWriteM    (RegWriteM),
    .MemtoRegE    (MemtoRegE),
    .RegWriteW    (RegWriteW),
    .MemtoRegW    (MemtoRegW),
    .PCSrcW       (PCSrcW),
    .PCWrPendingF (PCWrPendingF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_NOP   = 32'hEC000000;
  localparam logic [31:0] I_ADD   = 32'hE2821005;
  localparam logic [31:0] I_CMP   = 32'hE1510001;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_BNE   = 32'h1A000002;
  localparam logic [31:0] I_LDR   = 32'hE5902004;
  localparam logic [31:0] I_LDREQ = 32'h05902004;
  localparam logic [31:0] I_MOVPC = 32'hE1A0F001;

  typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_EOR, K_MOV, K_CMP,
                K_LDR, K_STR, K_B, K_NOP} kind_t;

  // What one instruction means to the pipeline, from the ISA rules.
  typedef struct packed {
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       alusrc;
    logic [3:0] aluop;
    logic       regw;
    logic       memw;
    logic       load;
    logic       branch;
    logic       pcs;
    logic [1:0] flagw;
    logic [3:0] cond;
  } dec_t;

  int n_vec;
  int n_err;

  dec_t       e_ins;
  logic       m_regw, m_memw, m_load, m_pcs;
  logic       w_regw, w_load, w_pcs;
  logic [3:0] nzcv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic kind_t classify(input logic [31:0] ins);
    logic [1:0] op;
    logic [3:0] cmd;
    op  = ins[27:26];
    cmd = ins[24:21];
    if (op == 2'b01) return ins[20] ? K_LDR : K_STR;
    if (op == 2'b10) return K_B;
    if (op == 2'b11) return K_NOP;
    case (cmd)
      4'b0100: return K_ADD;
      4'b0010: return K_SUB;
      4'b0000: return K_AND;
      4'b1100: return K_ORR;
      4'b0001: return K_EOR;
      4'b1101: return K_MOV;
      4'b1010: return K_CMP;
      default: return K_NOP;
    endcase
  endfunction

  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t  d;
    kind_t k;
    logic  s;
    d      = '0;
    k      = classify(ins);
    s      = ins[20];
    d.cond = ins[31:28];
    if (ins[27:26] == 2'b00) d.alusrc = ins[25];
    case (k)
      K_ADD: begin d.aluop = 4'd0; d.regw = 1; d.flagw = s ? 2'b11 : 2'b00; end
      K_SUB: begin d.aluop = 4'd1; d.regw = 1; d.flagw = s ? 2'b11 : 2'b00; end
      K_AND: begin d.aluop = 4'd2; d.regw = 1; d.flagw = s ? 2'b10 : 2'b00; end
      K_ORR: begin d.aluop = 4'd3; d.regw = 1; d.flagw = s ? 2'b10 : 2'b00; end
      K_EOR: begin d.aluop = 4'd4; d.regw = 1; d.flagw = s ? 2'b10 : 2'b00; end
      K_MOV: begin d.aluop = 4'd5; d.regw = 1; d.flagw = s ? 2'b10 : 2'b00; end
      K_CMP: begin d.aluop = 4'd1; d.flagw = 2'b11; end
      K_LDR, K_STR: begin
        d.immsrc = 2'b01;
        d.alusrc = 1;
        d.aluop  = ins[23] ? 4'd0 : 4'd1;
        if (k == K_LDR) begin d.regw = 1; d.load = 1; end
        else begin d.memw = 1; d.regsrc = 2'b10; end
      end
      K_B: begin d.regsrc = 2'b01; d.immsrc = 2'b10; d.alusrc = 1; d.branch = 1; end
      default: ;
    endcase
    d.pcs = d.regw && (ins[15:12] == 4'hF);
    return d;
  endfunction

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    e_ins  = '0;
    m_regw = 0; m_memw = 0; m_load = 0; m_pcs = 0;
    w_regw = 0; w_load = 0; w_pcs = 0;
    nzcv   = 4'b0000;
  endtask

  task automatic check_all();
    dec_t d;
    bit   ok;
    d  = model_decode(InstrD);
    ok = cond_holds(e_ins.cond, nzcv);
    check("RegSrcD",      32'(RegSrcD),      32'(d.regsrc));
    check("ImmSrcD",      32'(ImmSrcD),      32'(d.immsrc));
    check("ALUSrcE",      32'(ALUSrcE),      32'(e_ins.alusrc));
    check("ALUControlE",  32'(ALUControlE),  32'(e_ins.aluop));
    check("BranchTakenE", 32'(BranchTakenE), 32'(e_ins.branch && ok));
    check("MemtoRegE",    32'(MemtoRegE),    32'(e_ins.load));
    check("MemWriteM",    32'(MemWriteM),    32'(m_memw));
    check("RegWriteM",    32'(RegWriteM),    32'(m_regw));
    check("RegWriteW",    32'(RegWriteW),    32'(w_regw));
    check("MemtoRegW",    32'(MemtoRegW),    32'(w_load));
    check("PCSrcW",       32'(PCSrcW),       32'(w_pcs));
    check("PCWrPendingF", 32'(PCWrPendingF), 32'(d.pcs || e_ins.pcs || m_pcs));
  endtask

  // Drive one cycle of inputs away from the rising edge and check the outputs.
  task automatic apply(input logic [31:0] ins, input logic [3:0] fl,
                       input logic fe, input logic rst);
    @(negedge clk);
    InstrD   = ins;
    ALUFlags = fl;
    FlushE   = fe;
    reset    = rst;
    #1;
    check_all();
  endtask

  // Move every in-flight instruction one stage on, as the rising edge does.
  task automatic advance();
    bit ok;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      ok = cond_holds(e_ins.cond, nzcv);
      if (ok && e_ins.flagw[1]) nzcv[3:2] = ALUFlags[3:2];
      if (ok && e_ins.flagw[0]) nzcv[1:0] = ALUFlags[1:0];
      w_regw = m_regw; w_load = m_load; w_pcs = m_pcs;
      m_regw = e_ins.regw && ok;
      m_memw = e_ins.memw && ok;
      m_load = e_ins.load;
      m_pcs  = e_ins.pcs && ok;
      e_ins  = model_decode(InstrD);
      if (FlushE) begin
        e_ins.regw = 0; e_ins.memw = 0; e_ins.load = 0;
        e_ins.branch = 0; e_ins.pcs = 0; e_ins.flagw = 2'b00;
      end
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [3:0] fl,
                      input logic fe, input logic rst);
    apply(ins, fl, fe, rst);
    advance();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [3:0]  valid_cmds [7];
    int          sel;
    valid_cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1010};
    ins = $urandom;
    ins[31:28] = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    sel = $urandom_range(0, 9);
    if (sel <= 5) begin
      ins[27:26] = 2'b00;
      if (sel != 0) ins[24:21] = valid_cmds[$urandom_range(0, 6)];
    end else if (sel <= 7) begin
      ins[27:26] = 2'b01;
    end else if (sel == 8) begin
      ins[27:26] = 2'b10;
    end else begin
      ins[27:26] = 2'b11;
    end
    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
    return ins;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    InstrD = I_NOP; ALUFlags = 4'b0000; FlushE = 0; reset = 1;
    model_clear();
    repeat (2) @(posedge clk);

    // Reset held two cycles with live instructions in D.
    step(I_MOVPC, 4'hF, 0, 1);
    step(I_LDR,   4'hF, 0, 1);
    apply(I_NOP, 4'h0, 0, 0);
    check("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    check("rst_ALUSrcE",   32'(ALUSrcE),   32'd0);
    check("rst_PCWr",      32'(PCWrPendingF), 32'd0);
    advance();

    // ADD R1,R2,#5
    step(I_ADD, 4'h0, 0, 0);
    apply(I_NOP, 4'h0, 0, 0);
    check("add_ALUSrcE", 32'(ALUSrcE), 32'd1);
    check("add_ALUCtlE", 32'(ALUControlE), 32'd0);
    advance();
    step(I_NOP, 4'h0, 0, 0);
    apply(I_NOP, 4'h0, 0, 0);
    check("add_RegWriteW", 32'(RegWriteW), 32'd1);
    check("add_MemtoRegW", 32'(MemtoRegW), 32'd0);
    advance();

    // CMP sets Z, then BEQ taken, BNE not taken.
    step(I_CMP, 4'h0, 0, 0);
    step(I_BEQ, 4'b0100, 0, 0);
    apply(I_BNE, 4'h0, 0, 0);
    check("beq_taken", 32'(BranchTakenE), 32'd1);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("bne_not_taken", 32'(BranchTakenE), 32'd0);
    advance();

    // LDR, then LDR flushed on its way into E.
    apply(I_LDR, 4'h0, 0, 0);
    check("ldr_RegSrcD", 32'(RegSrcD), 32'd0);
    check("ldr_ImmSrcD", 32'(ImmSrcD), 32'd1);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("ldr_MemtoRegE", 32'(MemtoRegE), 32'd1);
    advance();
    step(I_NOP, 4'h0, 0, 0);
    apply(I_NOP, 4'h0, 0, 0);
    check("ldr_MemtoRegW", 32'(MemtoRegW), 32'd1);
    check("ldr_RegWriteW", 32'(RegWriteW), 32'd1);
    advance();
    step(I_LDR, 4'h0, 1, 0);
    apply(I_NOP, 4'h0, 0, 0);
    check("flush_MemtoRegE", 32'(MemtoRegE), 32'd0);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("flush_RegWriteM", 32'(RegWriteM), 32'd0);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("flush_RegWriteW", 32'(RegWriteW), 32'd0);
    advance();

    // Clear Z, then LDREQ must not write.
    step(I_CMP, 4'h0, 0, 0);
    step(I_LDREQ, 4'h0, 0, 0);
    step(I_NOP, 4'h0, 0, 0);
    apply(I_NOP, 4'h0, 0, 0);
    check("ldreq_RegWriteM", 32'(RegWriteM), 32'd0);
    check("ldreq_MemWriteM", 32'(MemWriteM), 32'd0);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("ldreq_RegWriteW", 32'(RegWriteW), 32'd0);
    advance();

    // MOV PC,R1
    apply(I_MOVPC, 4'h0, 0, 0);
    check("movpc_pend_t0", 32'(PCWrPendingF), 32'd1);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("movpc_pend_t1", 32'(PCWrPendingF), 32'd1);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("movpc_pend_t2", 32'(PCWrPendingF), 32'd1);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("movpc_PCSrcW_t3", 32'(PCSrcW), 32'd1);
    advance();
    apply(I_NOP, 4'h0, 0, 0);
    check("movpc_PCSrcW_t4", 32'(PCSrcW), 32'd0);
    advance();

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      step(rand_instr(), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
